sdram_rw_checker: RTL and testbench
===================================

# sdram_rw_checker

Self-checking traffic engine that sits directly upstream of the SDRAM controller top, on its user-side FIFO ports. It clears both FIFOs, pushes an incrementing word pattern into the write FIFO, waits for the controller to move the data through SDRAM into the read FIFO, then pops and compares every word. It reports a pass/fail verdict and error statistics for board bring-up and regression.

## Interface
- DSIZE, 16, data word width; matches controller data bus.
- NWORDS, 1000, words written then read back (1..65535).
- SEED, 0, value of the first word written.
- DRAIN_CYCLES, 5000, Clk cycles waited between the last write and the first read.
- Clk  in  1  single clock; also drives the Wr_clk/Rd_clk FIFO ports.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  level; a run begins when sampled high in IDLE with Init_done high.
- Init_done  in  1  SDRAM initialisation complete, from the controller.
- Wr_full  in  1  write FIFO full.
- Rd_empty  in  1  read FIFO empty.
- Rd_data  in  DSIZE  read FIFO data, valid the cycle after an accepted pop.
- Wr_load  out  1  write FIFO/address clear pulse.
- Rd_load  out  1  read FIFO/address clear pulse.
- Wr_en  out  1  write FIFO push.
- Wr_data  out  DSIZE  pushed word.
- Rd_en  out  1  read FIFO pop.
- Busy  out  1  high in every state except IDLE and DONE.
- Done  out  1  high in DONE, held until next Start.
- Pass  out  1  valid while Done: 1 when Err_cnt == 0.
- Err_cnt  out  16  mismatch count, saturates at 16'hFFFF.
- First_err_idx  out  16  word index of first mismatch; 0 when none.

## Operation
- States: IDLE, LOAD, WRITE, DRAIN, READ, FLUSH, DONE.
- IDLE -> LOAD when Start && Init_done. DONE -> LOAD likewise (rerun); DONE otherwise holds.
- Entering LOAD clears Err_cnt, First_err_idx, Pass, Done, and all counters.
- LOAD: Wr_load = Rd_load = 1 for exactly 2 cycles, then WRITE.
- WRITE: Wr_en = 1 in any cycle where !Wr_full and wr_cnt < NWORDS; Wr_data = (SEED + wr_cnt) mod 2^DSIZE, registered together with Wr_en; wr_cnt increments per push. When wr_cnt reaches NWORDS -> DRAIN.
- DRAIN: count DRAIN_CYCLES cycles, then READ.
- READ: Rd_en = 1 in any cycle where !Rd_empty and rd_cnt < NWORDS; rd_cnt increments per pop. One cycle after each pop, compare Rd_data with (SEED + chk_cnt) mod 2^DSIZE, chk_cnt increments. When rd_cnt reaches NWORDS -> FLUSH.
- FLUSH: one cycle completing the final compare, then DONE.
- Mismatch: Err_cnt += 1 (saturating); on the first mismatch of a run, First_err_idx = chk_cnt.
- Pass = (Err_cnt == 0), registered on entry to DONE.
- Start while Busy is ignored. Init_done dropping mid-run is ignored; the run completes.
- No timeout: if the read FIFO never supplies NWORDS words, the block stays in READ.

## Timing
- All outputs registered. Reset values: every output 0; state IDLE.
- Reset mid-run: asynchronous return to IDLE, all outputs 0 immediately. No partial state survives.
- Start sampled at cycle T -> Wr_load/Rd_load high on cycles T+1 and T+2 -> first Wr_en no earlier than T+3.
- Wr_full is sampled the same cycle Wr_en is driven: when Wr_full is high, Wr_en is low that cycle. No word is dropped or duplicated.
- The last push is followed on the next cycle by DRAIN. READ begins DRAIN_CYCLES cycles later.
- Pop-to-compare latency: exactly 1 cycle. Back-to-back pops are allowed every cycle.
- Done rises 2 cycles after the final pop: FLUSH, then DONE.
- Data wraps modulo 2^DSIZE; counters are 16-bit and never exceed NWORDS.

## Test plan
- Clean loopback: behavioural FIFO+memory model with depth ≥ 1000 and NWORDS=1000, SEED=0 -> Wr_data 0..999 pushed in order; Done=1, Pass=1, Err_cnt=0, First_err_idx=0.
- Backpressure: Wr_full toggled pseudo-randomly for 30% of cycles -> exactly NWORDS pushes, no Wr_en while Wr_full is high, still Pass=1.
- Corruption: the model flips bit 0 of words 17 and 500 -> Err_cnt=2, First_err_idx=17, Pass=0.
- Wrap: DSIZE=8, SEED=8'hF0, NWORDS=32 -> written words F0..FF, 00..0F; Pass=1.
- Gating: Start=1 with Init_done=0 -> stays in IDLE; Init_done then rises -> Wr_load high on the next 2 cycles. Start re-pulsed while Busy -> no effect.
- Reset mid-READ: Rst_n low at word 300 -> all outputs 0 asynchronously. After release plus Start, a full fresh run completes with Pass=1.

Source files
------------

// File: rtl/sdram_rw_checker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rw_checker
// Description : Self-checking traffic engine for the SDRAM controller's
//               user-side FIFO ports. Clears both FIFOs, writes NWORDS
//               incrementing words starting at SEED, waits DRAIN_CYCLES for
//               the controller to move them through SDRAM, then pops and
//               compares every word, reporting a verdict and error stats.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk_i            clock (also the FIFO write/read clock)
//   Rst_n_i          asynchronous active-low reset
//   Start_i          run request (level, honoured in IDLE/DONE with Init_done)
//   Init_done_i      controller initialisation complete
//   Wr_full_i        write FIFO full
//   Rd_empty_i       read FIFO empty
//   Rd_data_i        read FIFO data, valid the cycle after a pop
//   Wr_load_o        write FIFO/address clear pulse
//   Rd_load_o        read FIFO/address clear pulse
//   Wr_en_o          write FIFO push
//   Wr_data_o        pushed word
//   Rd_en_o          read FIFO pop
//   Busy_o           run in progress
//   Done_o           run finished, held until next run starts
//   Pass_o           verdict, valid while Done_o
//   Err_cnt_o        saturating mismatch count
//   First_err_idx_o  word index of the first mismatch (0 when none)
// ============================================================================
module sdram_rw_checker #(
   parameter int          DSIZE        = 16,
   parameter int          NWORDS       = 1000,
   parameter int unsigned SEED         = 0,
   parameter int          DRAIN_CYCLES = 5000
) (
   input  logic             Clk_i,
   input  logic             Rst_n_i,
   input  logic             Start_i,
   input  logic             Init_done_i,
   input  logic             Wr_full_i,
   input  logic             Rd_empty_i,
   input  logic [DSIZE-1:0] Rd_data_i,
   output logic             Wr_load_o,
   output logic             Rd_load_o,
   output logic             Wr_en_o,
   output logic [DSIZE-1:0] Wr_data_o,
   output logic             Rd_en_o,
   output logic             Busy_o,
   output logic             Done_o,
   output logic             Pass_o,
   output logic [15:0]      Err_cnt_o,
   output logic [15:0]      First_err_idx_o
);

   localparam logic [15:0]      C_NWORDS     = 16'(NWORDS);
   localparam logic [15:0]      C_LAST_IDX   = 16'(NWORDS - 1);
   localparam logic [DSIZE-1:0] C_SEED       = DSIZE'(SEED);
   // DRAIN always lasts at least one cycle, even for DRAIN_CYCLES of 0.
   localparam logic [31:0]      C_DRAIN_LAST = (DRAIN_CYCLES > 1) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_DRAIN = 3'd3,
      S_READ  = 3'd4,
      S_FLUSH = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t           state_q,     state_d;
   logic             load_cnt_q,  load_cnt_d;
   logic [15:0]      wr_cnt_q,    wr_cnt_d;
   logic [15:0]      rd_cnt_q,    rd_cnt_d;
   logic [15:0]      chk_cnt_q,   chk_cnt_d;
   logic [31:0]      drain_cnt_q, drain_cnt_d;
   logic [DSIZE-1:0] wr_data_q,   wr_data_d;
   logic             chk_pend_q,  chk_pend_d;
   logic             load_q,      load_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             pass_q,      pass_d;
   logic [15:0]      err_cnt_q,   err_cnt_d;
   logic [15:0]      first_err_q, first_err_d;

   logic             w_push;
   logic             w_pop;
   logic [DSIZE-1:0] w_exp;
   logic             w_mismatch;

   // Push/pop strobes are gated combinationally by the FIFO flags of the same
   // cycle, so a push never coincides with Wr_full and a pop never with
   // Rd_empty. Both are derived only from registered state plus those flags.
   assign w_push     = (state_q == S_WRITE) && !Wr_full_i  && (wr_cnt_q < C_NWORDS);
   assign w_pop      = (state_q == S_READ)  && !Rd_empty_i && (rd_cnt_q < C_NWORDS);
   assign w_exp      = C_SEED + DSIZE'(chk_cnt_q);
   assign w_mismatch = chk_pend_q && (Rd_data_i != w_exp);

   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      chk_cnt_d   = chk_cnt_q;
      drain_cnt_d = drain_cnt_q;
      wr_data_d   = wr_data_q;
      chk_pend_d  = w_pop;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      pass_d      = pass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start_i && Init_done_i) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            load_cnt_d = 1'b1;
            if (load_cnt_q) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_push) begin
               wr_cnt_d  = wr_cnt_q + 16'd1;
               wr_data_d = wr_data_q + DSIZE'(1);
               if (wr_cnt_q == C_LAST_IDX) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 32'd1;
            if (drain_cnt_q == C_DRAIN_LAST) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (w_pop) begin
               rd_cnt_d = rd_cnt_q + 16'd1;
               if (rd_cnt_q == C_LAST_IDX) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Compare stage runs one cycle behind each pop (READ or FLUSH).
      if (chk_pend_q) begin
         chk_cnt_d = chk_cnt_q + 16'd1;
         if (w_mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
               first_err_d = chk_cnt_q;
            end
         end
      end

      // Verdict includes the final compare, which completes in FLUSH.
      if (state_q == S_FLUSH) begin
         pass_d = (err_cnt_d == 16'd0);
      end

      // A new run starts from a clean slate.
      if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
         load_cnt_d  = 1'b0;
         wr_cnt_d    = 16'd0;
         rd_cnt_d    = 16'd0;
         chk_cnt_d   = 16'd0;
         drain_cnt_d = 32'd0;
         wr_data_d   = C_SEED;
         err_cnt_d   = 16'd0;
         first_err_d = 16'd0;
         pass_d      = 1'b0;
      end

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      load_d = (state_d == S_LOAD);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge Clk_i or negedge Rst_n_i) begin
      if (!Rst_n_i) begin
         state_q     <= S_IDLE;
         load_cnt_q  <= 1'b0;
         wr_cnt_q    <= 16'd0;
         rd_cnt_q    <= 16'd0;
         chk_cnt_q   <= 16'd0;
         drain_cnt_q <= 32'd0;
         wr_data_q   <= '0;
         chk_pend_q  <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_cnt_q   <= 16'd0;
         first_err_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         chk_cnt_q   <= chk_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         wr_data_q   <= wr_data_d;
         chk_pend_q  <= chk_pend_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
      end
   end

   assign Wr_load_o       = load_q;
   assign Rd_load_o       = load_q;
   assign Wr_en_o         = w_push;
   assign Wr_data_o       = wr_data_q;
   assign Rd_en_o         = w_pop;
   assign Busy_o          = busy_q;
   assign Done_o          = done_q;
   assign Pass_o          = pass_q;
   assign Err_cnt_o       = err_cnt_q;
   assign First_err_idx_o = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rw_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_rw_checker
// Description : Bench for sdram_rw_checker. A behavioural FIFO+memory
//               loopback feeds written words back to the read side; a
//               scoreboard queue holds the expected write stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_rw_checker;

   localparam int          DSIZE  = 16;
   localparam int          NWORDS = 600;
   localparam int unsigned SEED   = 32'h0000_FF00;  // stream wraps at word 256
   localparam int          DRAIN  = 20;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start     = 1'b0;
   logic        init_done = 1'b0;
   logic        wr_full   = 1'b0;
   logic        rd_empty  = 1'b1;
   logic [15:0] rd_data   = 16'h0;

   logic        wr_load, rd_load, wr_en, rd_en, busy, done, pass;
   logic [15:0] wr_data, err_cnt, first_err;

   sdram_rw_checker #(
      .DSIZE        (DSIZE),
      .NWORDS       (NWORDS),
      .SEED         (SEED),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .Clk_i           (clk),
      .Rst_n_i         (rst_n),
      .Start_i         (start),
      .Init_done_i     (init_done),
      .Wr_full_i       (wr_full),
      .Rd_empty_i      (rd_empty),
      .Rd_data_i       (rd_data),
      .Wr_load_o       (wr_load),
      .Rd_load_o       (rd_load),
      .Wr_en_o         (wr_en),
      .Wr_data_o       (wr_data),
      .Rd_en_o         (rd_en),
      .Busy_o          (busy),
      .Done_o          (done),
      .Pass_o          (pass),
      .Err_cnt_o       (err_cnt),
      .First_err_idx_o (first_err)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- loopback model + scoreboard ----------------
   logic [15:0] mem_q[$];
   logic [15:0] exp_wr[$];
   logic [15:0] rd_word;
   logic [63:0] sb_exp;
   int          edge_n = 0;
   int          push_cnt, pop_idx, full_viol;
   int          first_push_edge, last_push_edge, first_pop_edge, last_pop_edge;
   bit          bp_en   = 1'b0;
   bit          corrupt = 1'b0;
   logic        push_s  = 1'b0;
   logic        pop_s   = 1'b0;
   logic [15:0] wdata_s = 16'h0;

   // Drive flags at negedge, then capture what the DUT will see at posedge.
   always @(negedge clk) begin
      wr_full  = bp_en && ($urandom_range(0, 99) < 30);
      rd_empty = (mem_q.size() == 0) || (bp_en && ($urandom_range(0, 99) < 20));
      #1;
      push_s  = wr_en;
      wdata_s = wr_data;
      pop_s   = rd_en;
      if (wr_en && wr_full) full_viol++;
   end

   always @(posedge clk) begin
      edge_n++;
      #1;
      if (push_s) begin
         if (push_cnt == 0) first_push_edge = edge_n;
         last_push_edge = edge_n;
         push_cnt++;
         sb_exp = (exp_wr.size() > 0) ? {48'h0, exp_wr.pop_front()} : 64'hDEAD_0000_0000_0000;
         chk("wr_data_stream", {48'h0, wdata_s}, sb_exp);
         mem_q.push_back(wdata_s);
      end
      if (pop_s) begin
         rd_word = (mem_q.size() > 0) ? mem_q.pop_front() : 16'hxxxx;
         if (corrupt && (pop_idx == 17 || pop_idx == 500)) rd_word[0] = ~rd_word[0];
         rd_data = rd_word;
         if (pop_idx == 0) first_pop_edge = edge_n;
         last_pop_edge = edge_n;
         pop_idx++;
      end
   end

   // ---------------- helpers ----------------
   int start_edge, done_edge;

   task automatic prep_run(input bit bp, input bit corr);
      mem_q.delete();
      exp_wr.delete();
      for (int i = 0; i < NWORDS; i++) exp_wr.push_back(16'(SEED + i));
      push_cnt = 0; pop_idx = 0; full_viol = 0;
      first_push_edge = 0; last_push_edge = 0; first_pop_edge = 0; last_pop_edge = 0;
      bp_en = bp; corrupt = corr;
   endtask

   task automatic start_run();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #2; start_edge = edge_n;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 5000; k++) begin
         @(posedge clk); #2;
         if (done) break;
      end
      done_edge = edge_n;
      chk("run_completes", {63'h0, done}, 64'h1);
   endtask

   function automatic logic [63:0] outvec();
      return {9'h0, wr_load, rd_load, wr_en, wr_data, rd_en, busy, done, pass, err_cnt, first_err};
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outvec(), 64'h0);
      rst_n = 1'b1;

      // Gating: Start without Init_done stays idle.
      start = 1'b1; init_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("gate_no_init", {62'h0, busy, wr_load}, 64'h0);
      prep_run(1'b0, 1'b0);
      init_done = 1'b1;
      @(posedge clk); #2; start_edge = edge_n;
      chk("load_cycle1", {61'h0, wr_load, rd_load, busy}, 64'h7);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #2;
      chk("load_cycle2", {61'h0, wr_load, rd_load, wr_en}, 64'h6);
      @(posedge clk); #2;
      chk("load_cycle3", {62'h0, wr_load, rd_load}, 64'h0);
      // Start re-pulsed and Init_done dropped mid-run are both ignored.
      repeat (10) @(negedge clk);
      start = 1'b1; init_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_while_busy", {62'h0, busy, wr_load}, 64'h2);
      start = 1'b0;
      wait_done();
      init_done = 1'b1;
      chk("first_push_latency", 64'(first_push_edge), 64'(start_edge + 3));
      chk("drain_gap", 64'(first_pop_edge), 64'(last_push_edge + DRAIN + 1));
      chk("done_latency", 64'(done_edge), 64'(last_pop_edge + 1));
      chk("clean_verdict", {30'h0, done, pass, err_cnt, first_err}, {30'h0, 2'b11, 32'h0});
      chk("clean_pushes", 64'(push_cnt), 64'(NWORDS));
      chk("clean_pops", 64'(pop_idx), 64'(NWORDS));
      repeat (5) @(negedge clk);
      chk("done_held", {62'h0, done, busy}, 64'h2);

      // Backpressure on both FIFOs; rerun straight from DONE.
      prep_run(1'b1, 1'b0);
      start_run();
      chk("rerun_clears_done", {62'h0, done, busy}, 64'h1);
      wait_done();
      chk("bp_pushes", 64'(push_cnt), 64'(NWORDS));
      chk("bp_no_push_when_full", 64'(full_viol), 64'h0);
      chk("bp_sb_drained", 64'(exp_wr.size()), 64'h0);
      chk("bp_verdict", {30'h0, done, pass, err_cnt, first_err}, {30'h0, 2'b11, 32'h0});
      bp_en = 1'b0;

      // Corruption of words 17 and 500.
      prep_run(1'b0, 1'b1);
      start_run();
      wait_done();
      chk("corrupt_err_cnt", 64'(err_cnt), 64'd2);
      chk("corrupt_first_idx", 64'(first_err), 64'd17);
      chk("corrupt_verdict", {62'h0, done, pass}, 64'h2);

      // Asynchronous reset in the middle of READ.
      prep_run(1'b0, 1'b0);
      start_run();
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (pop_idx >= 300) break;
      end
      chk("reached_word_300", {63'h0, pop_idx >= 300}, 64'h1);
      #3 rst_n = 1'b0;
      #1 chk("async_reset_outputs", outvec(), 64'h0);
      repeat (3) @(negedge clk);
      chk("reset_held_idle", outvec(), 64'h0);
      prep_run(1'b0, 1'b0);
      rst_n = 1'b1;
      start_run();
      wait_done();
      chk("fresh_run_pushes", 64'(push_cnt), 64'(NWORDS));
      chk("fresh_run_verdict", {30'h0, done, pass, err_cnt, first_err}, {30'h0, 2'b11, 32'h0});

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
`default_nettype wire
